// File: rtl/mdio_datapath.sv
// MDIO slave datapath: pad synchronisers, bit sampling, field capture,
// register strobes and serial read-data output.
module mdio_datapath #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        soft_reset,
   input  logic        mdc,
   input  logic        mdio_in,
   output logic        mdio_out,
   input  logic [4:0]  phy_addr,
   output logic        update_stage,
   output logic        recent_rx_bit,
   output logic        is_write,
   input  logic [3:0]  mdio_out_cnt,
   input  logic        data_phase,
   input  logic        opcode_ready,
   input  logic        phyadr_ready,
   input  logic        devadr_ready,
   input  logic        data_ready,
   output logic [4:0]  reg_devad,
   output logic [15:0] reg_addr,
   output logic        reg_wr_en,
   output logic [15:0] reg_wr_data,
   output logic        reg_rd_en,
   input  logic [15:0] reg_rd_data
);

   logic [SYNC_STAGES-1:0] mdc_sync;
   logic [SYNC_STAGES-1:0] mdio_sync;
   logic                   mdc_d;
   logic                   mdc_s;
   logic                   mdio_s;
   logic                   rise;
   logic [14:0]            sr;
   logic [1:0]             op_q;
   logic                   match_q;
   logic [15:0]            rd_q;
   logic                   rd_pend;
   logic [4:0]             field5;
   logic [15:0]            word16;

   assign mdc_s  = mdc_sync[SYNC_STAGES-1];
   assign mdio_s = mdio_sync[SYNC_STAGES-1];
   assign rise   = mdc_s & ~mdc_d;

   // Fields end with the bit sampled at the current strobe.
   assign field5 = {sr[3:0], recent_rx_bit};
   assign word16 = {sr, recent_rx_bit};

   assign is_write = ~op_q[1] | ~match_q;
   assign mdio_out = data_phase ? rd_q[4'd15 - mdio_out_cnt] : 1'b0;

   always_ff @(posedge clk) begin
      if (soft_reset) begin
         mdc_sync      <= '0;
         mdio_sync     <= '0;
         mdc_d         <= 1'b0;
         update_stage  <= 1'b0;
         recent_rx_bit <= 1'b0;
         sr            <= '0;
         op_q          <= '0;
         match_q       <= 1'b0;
         rd_q          <= '0;
         rd_pend       <= 1'b0;
         reg_devad     <= '0;
         reg_addr      <= '0;
         reg_wr_data   <= '0;
         reg_wr_en     <= 1'b0;
         reg_rd_en     <= 1'b0;
      end else begin
         mdc_sync     <= {mdc_sync[SYNC_STAGES-2:0], mdc};
         mdio_sync    <= {mdio_sync[SYNC_STAGES-2:0], mdio_in};
         mdc_d        <= mdc_s;
         update_stage <= rise;
         if (rise)
            recent_rx_bit <= mdio_s;
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
         rd_pend   <= reg_rd_en;
         if (rd_pend)
            rd_q <= reg_rd_data;
         if (update_stage) begin
            sr <= {sr[13:0], recent_rx_bit};
            if (opcode_ready)
               op_q <= {sr[0], recent_rx_bit};
            if (phyadr_ready)
               match_q <= (field5 == phy_addr);
            if (devadr_ready) begin
               reg_devad <= field5;
               if (match_q && op_q[1])
                  reg_rd_en <= 1'b1;
            end
            if (data_ready && match_q) begin
               unique case (1'b1)
                  op_q == 2'b00: reg_addr <= word16;
                  op_q == 2'b01: begin
                     reg_wr_data <= word16;
                     reg_wr_en   <= 1'b1;
                  end
                  op_q == 2'b10: reg_addr <= reg_addr + 16'd1;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
